ctrl_pipe: RTL
==============

# ctrl_pipe

Pipelined control unit for the TSC CPU. It decodes the ID-stage instruction into a control bundle and carries that bundle through ID/EX, a configurable number of MEM registers and MEM/WB. It also applies load-use bubbles, branch flushes and cache-miss freezes, and tracks halt, illegal-instruction and retirement state. The datapath consumes its per-stage outputs directly, so no control bits need to be staged in the datapath.

## Interface
Clock is `clk`; reset is `reset`, asynchronous, active-high.

Parameters:
- `MEM_STAGES`, default 1: number of MEM pipeline registers, legal range 1..4.
- `REG_ADDR_W`, default 2: register-index width.
- `LINK_REG`, default 2: destination register for JAL and JRL.
- `NUM_INST_W`, default 16: width of the retirement counter.

Ports (clock and reset first):
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `id_valid` in 1: ID holds a real instruction.
- `id_opcode` in 4: opcode field.
- `id_func` in 6: function field.
- `id_rt`, `id_rd` in REG_ADDR_W: register fields.
- `hold_id` in 1: load-use stall; insert a bubble into EX.
- `flush` in 1: branch/jump redirect; kill the ID instruction.
- `freeze` in 1: cache miss; every stage register holds.
- `id_pc_source` out 2: combinational PCSRC_* value.
- `id_is_jump` out 1: combinational; JMP, JAL, JPR or JRL.
- `ex_valid`, `ex_is_branch` out 1.
- `ex_alu_op` out 4: OP_* value.
- `ex_alu_src_b` out 2: ALUSRCB_* value.
- `mem_valid`, `mem_read`, `mem_write` out 1: first MEM stage only.
- `wb_valid`, `wb_reg_write`, `wb_output_active` out 1.
- `wb_dest` out REG_ADDR_W.
- `wb_mem_to_reg` out 2: REGWRITESRC_* value.
- `is_halted` out 1: sticky.
- `illegal_inst` out 1: sticky.
- `num_inst` out NUM_INST_W.

## Operation
Decode:
- Use the standard TSC ISA decode, with encodings from the team opcode/constants headers.
- Bundle fields: alu_op, alu_src_b, is_branch, mem_read, mem_write, reg_write, dest, mem_to_reg, output_active, is_halt.
- `dest` selection:
  - JAL and JRL → LINK_REG.
  - Other R-type → `id_rd`.
  - Everything else → `id_rt`.
- An undefined opcode/func with `id_valid`=1 decodes as a bubble and sets `illegal_inst`.

Per-edge priority (highest first):
1. `reset`
2. `freeze`: all registers hold, counters hold.
3. `flush` or `hold_id`: ID/EX loads a bubble; older stages advance.
4. Normal: every stage advances.

Bubble definition: valid=0 and every write/read/output enable is 0. Datapath fields are don't-care but are driven to 0.

Halt handling:
- `halt_pending` sets when a HLT is accepted into ID/EX.
- While `halt_pending`=1, ID/EX accepts only bubbles.
- `is_halted` sets on the edge where WB holds a valid HLT and `freeze`=0.
- `halt_pending` and `is_halted` clear only on reset.

Retirement: on each edge with `wb_valid`=1 and `freeze`=0, `num_inst` increments, wrapping modulo 2^NUM_INST_W. Bubbles and a frozen WB are never counted; a frozen WB instruction is counted once only, when it leaves.

## Timing
- ID outputs are combinational from the `id_*` inputs and are gated by `id_valid`.
- Stage latency after ID acceptance:
  - EX fields: 1 cycle.
  - First MEM stage: 2 cycles.
  - WB fields: 2+MEM_STAGES cycles.
- `mem_read` and `mem_write` are asserted only in the first MEM stage, for exactly one non-frozen cycle per instruction. Frozen cycles extend this.
- Reset values: every output is 0, `num_inst` is 0, and all stage valids are 0. Reset mid-operation discards all in-flight instructions immediately (asynchronous).
- `flush` and `hold_id` asserted together act as a single bubble.
- `freeze` asserted together with `flush` or `hold_id`: freeze wins. The datapath re-presents the flush/hold after the freeze ends.

## Configuration
- `CTRL_RETIRE_CNT_EN` defined: `num_inst` counts as specified above.
- Not defined: no counter flops are built and `num_inst` is tied to 0. All other behaviour is identical.

## Test plan
- **Straight line.** ADI (op 4) rt=1, then LWD (op 7) rt=2, then SWD (op 8).
  - ex_alu_op = OP_ADD with ALUSRCB_IMM on cycles 1, 2 and 3.
  - mem_read=1 on cycle 3 only (MEM_STAGES=1).
  - WB: dest 1 with REGWRITESRC_ALU, then dest 2 with REGWRITESRC_MEM; SWD has reg_write=0.
  - num_inst=3.
- **Link writes.** JAL (op 10) → id_is_jump=1 and PCSRC_JUMP in ID; WB shows dest=2 and REGWRITESRC_PC. JRL (op 15, func 26) → PCSRC_REG.
- **Hold and flush.** hold_id during LWD→ADD → a single EX bubble with ex_valid=0. flush on BEQ (op 1) → the instruction behind it never reaches WB. num_inst excludes both.
- **Freeze.** With MEM_STAGES=2, freeze for 5 cycles while SWD is in MEM1 → mem_write stays 1 for 6 cycles, WB unchanged, num_inst unchanged, one retirement afterward.
- **Halt.** HLT (op 15, func 29) followed by ADI → the ADI is ignored, is_halted rises 4 cycles after HLT enters ID (MEM_STAGES=1) and stays 1; reset clears it.
- **Illegal and counter options.** Opcode 13 with id_valid=1 → illegal_inst=1 and a bubble. Counter wrap with NUM_INST_W=2: 5 retirements → num_inst=1. Without CTRL_RETIRE_CNT_EN → num_inst=0 throughout.

Source files
------------

// File: rtl/ctrl_pipe.sv
// TSC pipelined control unit: ID decode plus ID/EX, MEM and MEM/WB control staging.
// Define CTRL_RETIRE_CNT_EN to build the retirement counter behind num_inst.
package ctrl_pipe_pkg;
    localparam logic [3:0] OPC_BNE   = 4'd0;
    localparam logic [3:0] OPC_BEQ   = 4'd1;
    localparam logic [3:0] OPC_BGZ   = 4'd2;
    localparam logic [3:0] OPC_BLZ   = 4'd3;
    localparam logic [3:0] OPC_ADI   = 4'd4;
    localparam logic [3:0] OPC_ORI   = 4'd5;
    localparam logic [3:0] OPC_LHI   = 4'd6;
    localparam logic [3:0] OPC_LWD   = 4'd7;
    localparam logic [3:0] OPC_SWD   = 4'd8;
    localparam logic [3:0] OPC_JMP   = 4'd9;
    localparam logic [3:0] OPC_JAL   = 4'd10;
    localparam logic [3:0] OPC_RTYPE = 4'd15;

    localparam logic [5:0] FN_SHR = 6'd7;
    localparam logic [5:0] FN_JPR = 6'd25;
    localparam logic [5:0] FN_JRL = 6'd26;
    localparam logic [5:0] FN_WWD = 6'd28;
    localparam logic [5:0] FN_HLT = 6'd29;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_ORR = 4'd3;
    localparam logic [3:0] OP_NOT = 4'd4;
    localparam logic [3:0] OP_TCP = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_SHR = 4'd7;
    localparam logic [3:0] OP_LHI = 4'd8;
    localparam logic [3:0] OP_BNE = 4'd9;
    localparam logic [3:0] OP_BEQ = 4'd10;
    localparam logic [3:0] OP_BGZ = 4'd11;
    localparam logic [3:0] OP_BLZ = 4'd12;

    localparam logic [1:0] ALUSRCB_REG  = 2'd0;
    localparam logic [1:0] ALUSRCB_IMM  = 2'd1;
    localparam logic [1:0] ALUSRCB_ZIMM = 2'd2;

    localparam logic [1:0] PCSRC_SEQ    = 2'd0;
    localparam logic [1:0] PCSRC_BRANCH = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;
    localparam logic [1:0] PCSRC_REG    = 2'd3;

    localparam logic [1:0] REGWRITESRC_ALU = 2'd0;
    localparam logic [1:0] REGWRITESRC_MEM = 2'd1;
    localparam logic [1:0] REGWRITESRC_PC  = 2'd2;
endpackage

module ctrl_pipe
    import ctrl_pipe_pkg::*;
#(
    parameter int MEM_STAGES = 1,
    parameter int REG_ADDR_W = 2,
    parameter int LINK_REG   = 2,
    parameter int NUM_INST_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [3:0]            id_opcode,
    input  logic [5:0]            id_func,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  hold_id,
    input  logic                  flush,
    input  logic                  freeze,
    output logic [1:0]            id_pc_source,
    output logic                  id_is_jump,
    output logic                  ex_valid,
    output logic                  ex_is_branch,
    output logic [3:0]            ex_alu_op,
    output logic [1:0]            ex_alu_src_b,
    output logic                  mem_valid,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  wb_valid,
    output logic                  wb_reg_write,
    output logic                  wb_output_active,
    output logic [REG_ADDR_W-1:0] wb_dest,
    output logic [1:0]            wb_mem_to_reg,
    output logic                  is_halted,
    output logic                  illegal_inst,
    output logic [NUM_INST_W-1:0] num_inst
);

    typedef struct packed {
        logic                  valid;
        logic                  regWrite;
        logic [REG_ADDR_W-1:0] dest;
        logic [1:0]            memToReg;
        logic                  outputActive;
        logic                  isHalt;
    } wbCtrl_t;

    typedef struct packed {
        logic    memRead;
        logic    memWrite;
        wbCtrl_t wb;
    } memCtrl_t;

    typedef struct packed {
        logic [3:0] aluOp;
        logic [1:0] aluSrcB;
        logic       isBranch;
        memCtrl_t   mem;
    } exCtrl_t;

    exCtrl_t  dec;
    exCtrl_t  exNext;
    exCtrl_t  exReg;
    memCtrl_t memReg [MEM_STAGES];
    wbCtrl_t  wbReg;

    logic       legal;
    logic       linkDest;
    logic [1:0] pcSrc;
    logic       isJump;
    logic       accept;
    logic       haltPending;
    logic       halted;
    logic       illegal;

    always_comb begin
        dec      = '0;
        legal    = 1'b0;
        linkDest = 1'b0;
        pcSrc    = PCSRC_SEQ;
        isJump   = 1'b0;
        unique case (id_opcode)
            OPC_BNE, OPC_BEQ, OPC_BGZ, OPC_BLZ: begin
                legal        = 1'b1;
                dec.isBranch = 1'b1;
                dec.aluOp    = OP_BNE + id_opcode;
                pcSrc        = PCSRC_BRANCH;
            end
            OPC_ADI: begin
                legal               = 1'b1;
                dec.aluOp           = OP_ADD;
                dec.aluSrcB         = ALUSRCB_IMM;
                dec.mem.wb.regWrite = 1'b1;
            end
            OPC_ORI: begin
                legal               = 1'b1;
                dec.aluOp           = OP_ORR;
                dec.aluSrcB         = ALUSRCB_ZIMM;
                dec.mem.wb.regWrite = 1'b1;
            end
            OPC_LHI: begin
                legal               = 1'b1;
                dec.aluOp           = OP_LHI;
                dec.aluSrcB         = ALUSRCB_IMM;
                dec.mem.wb.regWrite = 1'b1;
            end
            OPC_LWD: begin
                legal               = 1'b1;
                dec.aluOp           = OP_ADD;
                dec.aluSrcB         = ALUSRCB_IMM;
                dec.mem.memRead     = 1'b1;
                dec.mem.wb.regWrite = 1'b1;
                dec.mem.wb.memToReg = REGWRITESRC_MEM;
            end
            OPC_SWD: begin
                legal            = 1'b1;
                dec.aluOp        = OP_ADD;
                dec.aluSrcB      = ALUSRCB_IMM;
                dec.mem.memWrite = 1'b1;
            end
            OPC_JMP: begin
                legal  = 1'b1;
                pcSrc  = PCSRC_JUMP;
                isJump = 1'b1;
            end
            OPC_JAL: begin
                legal               = 1'b1;
                pcSrc               = PCSRC_JUMP;
                isJump              = 1'b1;
                linkDest            = 1'b1;
                dec.mem.wb.regWrite = 1'b1;
                dec.mem.wb.memToReg = REGWRITESRC_PC;
            end
            OPC_RTYPE: begin
                unique case (1'b1)
                    (id_func <= FN_SHR): begin
                        legal               = 1'b1;
                        dec.aluOp           = id_func[3:0];
                        dec.mem.wb.regWrite = 1'b1;
                    end
                    (id_func == FN_JPR): begin
                        legal  = 1'b1;
                        pcSrc  = PCSRC_REG;
                        isJump = 1'b1;
                    end
                    (id_func == FN_JRL): begin
                        legal               = 1'b1;
                        pcSrc               = PCSRC_REG;
                        isJump              = 1'b1;
                        linkDest            = 1'b1;
                        dec.mem.wb.regWrite = 1'b1;
                        dec.mem.wb.memToReg = REGWRITESRC_PC;
                    end
                    (id_func == FN_WWD): begin
                        legal                   = 1'b1;
                        dec.mem.wb.outputActive = 1'b1;
                    end
                    (id_func == FN_HLT): begin
                        legal             = 1'b1;
                        dec.mem.wb.isHalt = 1'b1;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
        dec.mem.wb.valid = legal;
        if (linkDest)
            dec.mem.wb.dest = REG_ADDR_W'(LINK_REG);
        else if (id_opcode == OPC_RTYPE)
            dec.mem.wb.dest = id_rd;
        else
            dec.mem.wb.dest = id_rt;
        // Undefined or absent instructions collapse to a clean bubble
        if (!(id_valid && legal)) begin
            dec    = '0;
            pcSrc  = PCSRC_SEQ;
            isJump = 1'b0;
        end
    end

    assign accept = !flush && !hold_id && !haltPending;
    assign exNext = accept ? dec : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exReg       <= '0;
            wbReg       <= '0;
            haltPending <= 1'b0;
            halted      <= 1'b0;
            illegal     <= 1'b0;
            for (int i = 0; i < MEM_STAGES; i++)
                memReg[i] <= '0;
        end else if (!freeze) begin
            exReg     <= exNext;
            memReg[0] <= exReg.mem;
            for (int i = 1; i < MEM_STAGES; i++)
                memReg[i] <= memReg[i-1];
            wbReg <= memReg[MEM_STAGES-1].wb;
            if (exNext.mem.wb.isHalt)
                haltPending <= 1'b1;
            if (accept && id_valid && !legal)
                illegal <= 1'b1;
            if (wbReg.valid && wbReg.isHalt)
                halted <= 1'b1;
        end
    end

`ifdef CTRL_RETIRE_CNT_EN
    logic [NUM_INST_W-1:0] numInst;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            numInst <= '0;
        else if (!freeze && wbReg.valid)
            numInst <= numInst + 1'b1;
    end

    assign num_inst = numInst;
`else
    assign num_inst = '0;
`endif

    assign id_pc_source     = pcSrc;
    assign id_is_jump       = isJump;
    assign ex_valid         = exReg.mem.wb.valid;
    assign ex_is_branch     = exReg.isBranch;
    assign ex_alu_op        = exReg.aluOp;
    assign ex_alu_src_b     = exReg.aluSrcB;
    assign mem_valid        = memReg[0].wb.valid;
    assign mem_read         = memReg[0].memRead;
    assign mem_write        = memReg[0].memWrite;
    assign wb_valid         = wbReg.valid;
    assign wb_reg_write     = wbReg.regWrite;
    assign wb_output_active = wbReg.outputActive;
    assign wb_dest          = wbReg.dest;
    assign wb_mem_to_reg    = wbReg.memToReg;
    assign is_halted        = halted;
    assign illegal_inst     = illegal;

endmodule
